// File: rtl/line_follow_ctrl_pkg.sv
// Shared types for the line-follower motor sequencer: FSM states,
// motor direction codes and the sensor-to-manoeuvre decision.
package line_follow_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FORWARD    = 3'd1,
    ST_TURN_LEFT  = 3'd2,
    ST_TURN_RIGHT = 3'd3,
    ST_SEARCH     = 3'd4,
    ST_STOP       = 3'd5
  } state_e;

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_BRAKE = 2'b00;

  function automatic int cnt_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  // Centre with a balanced (or empty) side, or a junction, drives straight on.
  function automatic state_e decide(input logic [4:0] s);
    logic r;
    logic l;
    logic c;
    state_e d;
    r = s[0] | s[1];
    l = s[3] | s[4];
    c = s[2];
    if (s == 5'b00000) d = ST_SEARCH;
    else if (c && !(r ^ l)) d = ST_FORWARD;
    else if (r && l) d = ST_FORWARD;
    else if (r) d = ST_TURN_RIGHT;
    else d = ST_TURN_LEFT;
    return d;
  endfunction

endpackage

// File: rtl/line_follow_ctrl_if.sv
// Control/status bundle between the car sequencer and its environment.
interface line_follow_ctrl_if;
  logic       enable;
  logic [4:0] senzori;
  logic [1:0] directie_driverA;
  logic [1:0] directie_driverB;
  logic       pwm_A;
  logic       pwm_B;
  logic       dreapta;
  logic       stanga;
  logic       linie_pierduta;
  logic [2:0] stare;

  modport master (
    output enable, senzori,
    input  directie_driverA, directie_driverB, pwm_A, pwm_B,
           dreapta, stanga, linie_pierduta, stare
  );

  modport slave (
    input  enable, senzori,
    output directie_driverA, directie_driverB, pwm_A, pwm_B,
           dreapta, stanga, linie_pierduta, stare
  );
endinterface

// File: rtl/line_follow_ctrl_filtru.sv
// Two-flop synchronizer followed by a stability filter: a new sensor
// vector is accepted only after DEB_CYCLES consecutive identical samples.
module filtru_senzori
  import line_follow_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int WIDTH      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_filt
);
  localparam int            CW       = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1, r_sync2, r_cand, r_filt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_cand_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  // Restart the stability count on any change, saturate at the terminal value.
  always_comb begin
    w_cand_nxt = r_cand;
    w_cnt_nxt  = r_cnt;
    if (r_sync2 != r_cand) begin
      w_cand_nxt = r_sync2;
      w_cnt_nxt  = {CW{1'b0}};
    end else if (r_cnt != CNT_LAST) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Synchronizer, candidate/counter and accepted-vector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= {WIDTH{1'b0}};
      r_sync2 <= {WIDTH{1'b0}};
      r_cand  <= {WIDTH{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_filt  <= {WIDTH{1'b0}};
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cnt_nxt == CNT_LAST) r_filt <= w_cand_nxt;
    end
  end

  assign o_filt = r_filt;
endmodule

// File: rtl/line_follow_ctrl.sv
// Line-follower sequencer: debounced sensors drive a Moore FSM that sets
// motor directions, a shared PWM duty, turn memory and a sticky lost flag.
module line_follow_ctrl
  import line_follow_pkg::*;
#(
  parameter int DEB_CYCLES  = 50000,
  parameter int LOST_CYCLES = 25000000,
  parameter int PWM_PERIOD  = 1000,
  parameter int DUTY_FWD    = 700,
  parameter int DUTY_TURN   = 500,
  parameter int DUTY_SEARCH = 400
) (
  input logic               clk,
  input logic               rst,
  line_follow_ctrl_if.slave io_car
);
  localparam int            LW        = cnt_w(LOST_CYCLES);
  localparam int            PW        = cnt_w(PWM_PERIOD);
  localparam logic [LW-1:0] LOST_LAST = LW'(LOST_CYCLES - 1);
  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);

  logic [4:0]    w_filt;
  state_e        r_state, w_state_nxt, w_dec;
  logic [LW-1:0] r_lost_cnt, w_lost_cnt_nxt;
  logic [PW-1:0] r_pwm_cnt, w_pwm_cnt_nxt;
  logic [1:0]    r_dir_a, r_dir_b, w_dir_a_nxt, w_dir_b_nxt;
  logic          r_pwm, r_dreapta, r_stanga, r_lost;
  logic          w_dreapta_nxt, w_stanga_nxt, w_lost_nxt;
  logic [31:0]   w_duty_nxt;

  filtru_senzori #(.DEB_CYCLES(DEB_CYCLES), .WIDTH(5)) u_filtru (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (io_car.senzori),
    .o_filt (w_filt)
  );

  // Next state; the lost counter defaults to zero so any non-SEARCH entry clears it.
  always_comb begin
    w_dec          = decide(w_filt);
    w_state_nxt    = r_state;
    w_lost_cnt_nxt = {LW{1'b0}};
    w_lost_nxt     = r_lost;
    if (!io_car.enable) begin
      w_state_nxt = ST_IDLE;
      w_lost_nxt  = 1'b0;
    end else begin
      case (r_state)
        // IDLE waits for a qualified line before moving at all.
        ST_IDLE: w_state_nxt = (w_dec == ST_SEARCH) ? ST_IDLE : w_dec;
        ST_FORWARD, ST_TURN_LEFT, ST_TURN_RIGHT: w_state_nxt = w_dec;
        ST_SEARCH: begin
          if (w_dec != ST_SEARCH) begin
            w_state_nxt = w_dec;
          end else if (r_lost_cnt == LOST_LAST) begin
            w_state_nxt = ST_STOP;
            w_lost_nxt  = 1'b1;
          end else begin
            w_state_nxt    = ST_SEARCH;
            w_lost_cnt_nxt = r_lost_cnt + LW'(1);
          end
        end
        ST_STOP: w_state_nxt = ST_STOP;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Turn memory and Moore output decode of the upcoming state.
  always_comb begin
    w_dreapta_nxt = r_dreapta;
    w_stanga_nxt  = r_stanga;
    if (w_state_nxt == ST_TURN_RIGHT) begin
      w_dreapta_nxt = 1'b1;
      w_stanga_nxt  = 1'b0;
    end else if (w_state_nxt == ST_TURN_LEFT) begin
      w_dreapta_nxt = 1'b0;
      w_stanga_nxt  = 1'b1;
    end else begin
      w_dreapta_nxt = r_dreapta;
      w_stanga_nxt  = r_stanga;
    end
    case (w_state_nxt)
      ST_FORWARD: begin
        w_dir_a_nxt = DIR_FWD; w_dir_b_nxt = DIR_FWD; w_duty_nxt = 32'(DUTY_FWD);
      end
      ST_TURN_RIGHT: begin
        w_dir_a_nxt = DIR_FWD; w_dir_b_nxt = DIR_REV; w_duty_nxt = 32'(DUTY_TURN);
      end
      ST_TURN_LEFT: begin
        w_dir_a_nxt = DIR_REV; w_dir_b_nxt = DIR_FWD; w_duty_nxt = 32'(DUTY_TURN);
      end
      ST_SEARCH: begin
        w_duty_nxt = 32'(DUTY_SEARCH);
        if (w_dreapta_nxt) begin
          w_dir_a_nxt = DIR_FWD; w_dir_b_nxt = DIR_REV;
        end else if (w_stanga_nxt) begin
          w_dir_a_nxt = DIR_REV; w_dir_b_nxt = DIR_FWD;
        end else begin
          w_dir_a_nxt = DIR_FWD; w_dir_b_nxt = DIR_FWD;
        end
      end
      default: begin
        w_dir_a_nxt = DIR_BRAKE; w_dir_b_nxt = DIR_BRAKE; w_duty_nxt = 32'd0;
      end
    endcase
    w_pwm_cnt_nxt = (r_pwm_cnt == PWM_LAST) ? {PW{1'b0}} : r_pwm_cnt + PW'(1);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lost_cnt <= {LW{1'b0}};
      r_pwm_cnt  <= {PW{1'b0}};
      r_dir_a    <= DIR_BRAKE;
      r_dir_b    <= DIR_BRAKE;
      r_pwm      <= 1'b0;
      r_dreapta  <= 1'b0;
      r_stanga   <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lost_cnt <= w_lost_cnt_nxt;
      r_pwm_cnt  <= w_pwm_cnt_nxt;
      r_dir_a    <= w_dir_a_nxt;
      r_dir_b    <= w_dir_b_nxt;
      r_pwm      <= (32'(w_pwm_cnt_nxt) < w_duty_nxt);
      r_dreapta  <= w_dreapta_nxt;
      r_stanga   <= w_stanga_nxt;
      r_lost     <= w_lost_nxt;
    end
  end

  assign io_car.directie_driverA = r_dir_a;
  assign io_car.directie_driverB = r_dir_b;
  assign io_car.pwm_A            = r_pwm;
  assign io_car.pwm_B            = r_pwm;
  assign io_car.dreapta          = r_dreapta;
  assign io_car.stanga           = r_stanga;
  assign io_car.linie_pierduta   = r_lost;
  assign io_car.stare            = r_state;
endmodule
